instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 12'h000, byte address loaded into the PC on reset; bits [1:0] SHALL be 0.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port fetch_en  input  1  high permits new fetches; low freezes the PC, but consumption of held output continues.
REQ-005 Port redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 Port redirect_target  input  12  byte address of the redirect destination.
REQ-007 Port imem_addr  output  12  byte address to instruction memory (word index = bits [11:2]).
REQ-008 Port imem_instr  input  32  instruction word returned combinationally for imem_addr, same cycle.
REQ-009 Port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 Port out_ready  input  1  downstream decoder accepts the held instruction this cycle.
REQ-011 Port out_instr  output  32  registered instruction word.
REQ-012 Port out_pc  output  12  byte address out_instr was fetched from.
REQ-013 Port misalign_err  output  1  one-cycle pulse: last accepted redirect_target had bits [1:0] != 0.

Function
REQ-014 imem_addr SHALL equal the PC register combinationally; PC bits [1:0] SHALL always be 0.
REQ-015 Handshake: transfer occurs in a cycle where out_valid=1 and out_ready=1.
REQ-016 load = fetch_en && (!out_valid || out_ready); on load with no redirect: out_instr<=imem_instr, out_pc<=PC, out_valid<=1, PC<=PC+4.
REQ-017 PC+4 SHALL wrap modulo 4096: 12'hFFC -> 12'h000; no error flagged.
REQ-018 Stall: out_valid=1 and out_ready=0 -> out_instr, out_pc, out_valid, PC all hold; outputs SHALL NOT change while stalled.
REQ-019 Transfer with fetch_en=0 -> out_valid<=0, PC holds, out_instr/out_pc hold last value.
REQ-020 fetch_en=0 and no transfer -> all state holds.
REQ-021 Redirect has priority over load and stall, independent of out_ready and fetch_en: PC<={redirect_target[11:2],2'b00}, out_valid<=0 (held instruction flushed, not delivered).
REQ-022 Redirect SHALL NOT capture imem_instr that cycle; first instruction from the target appears at out_* one cycle after redirect (if fetch_en=1 then).
REQ-023 misalign_err<=1 for exactly the cycle after a redirect whose target[1:0]!=0, else 0; target is still taken with bits [1:0] cleared.
REQ-024 Throughput: with fetch_en=1, out_ready=1, no redirect, one instruction per cycle, out_pc increasing by 4.
REQ-025 Back-to-back redirects: each SHALL overwrite PC; only the last target is fetched.

Reset
REQ-026 rst_n=0 SHALL immediately (no clock edge) set PC=RESET_PC, out_valid=0, out_instr=32'h0, out_pc=12'h000, misalign_err=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first fetch after deassertion is from RESET_PC on the first rising edge with fetch_en=1.
REQ-028 No output SHALL toggle while rst_n=0 regardless of other inputs.

Verification
REQ-029 Reset then fetch_en=1, out_ready=1, memory word n = 32'h1000_0000+n -> out_pc 0x000,0x004,0x008 with out_instr 0x10000000,0x10000001,0x10000002 on consecutive cycles.
REQ-030 out_valid=1 holding out_pc=0x008, out_ready=0 for 3 cycles -> out_instr/out_pc/imem_addr=0x00C unchanged; out_ready=1 -> 0x00C delivered next cycle.
REQ-031 Stalled at out_pc=0x010, redirect_valid=1 target 0x100 -> next cycle out_valid=0, imem_addr=0x100; following cycle out_pc=0x100; 0x010 never transferred.
REQ-032 Redirect target 0x203 -> misalign_err=1 one cycle, imem_addr=0x200, next delivered out_pc=0x200.
REQ-033 Redirect to 0xFFC, free-running -> out_pc 0xFFC then 0x000, misalign_err stays 0.
REQ-034 rst_n pulsed low between clock edges during stall at 0x040 -> outputs zero/out_valid=0 immediately; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a PC register addresses a combinational instruction memory,
// and a single output register holds the fetched word under a valid/ready handshake.
module instr_fetch #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_target,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [11:0] out_pc,
    output logic        misalign_err
);

    logic [11:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [11:0] opc_q, opc_d;
    logic        mis_q, mis_d;

    logic load;
    logic transfer;

    assign load     = fetch_en && (!valid_q || out_ready);
    assign transfer = valid_q && out_ready;

    // Redirect outranks everything: it flushes the held word and never captures imem_instr.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        mis_d   = 1'b0;
        if (redirect_valid) begin
            pc_d    = {redirect_target[11:2], 2'b00};
            valid_d = 1'b0;
            mis_d   = |redirect_target[1:0];
        end else if (load) begin
            instr_d = imem_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 12'd4;
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= {RESET_PC[11:2], 2'b00};
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = opc_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a cycle-level behavioural model.
module tb_instr_fetch;

    localparam logic [11:0] RPC = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [11:0] out_pc;
    logic        misalign_err;

    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    // Reference state, derived from the fetch rules with plain arithmetic.
    int unsigned m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    int unsigned m_opc;
    bit          m_mis;

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    assign imem_instr = mem[imem_addr[11:2]];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = int'(RPC);
        m_valid = 0;
        m_instr = 32'h0;
        m_opc   = 0;
        m_mis   = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (redirect_valid) begin
            m_pc    = (int'(redirect_target) / 4) * 4;
            m_valid = 0;
            m_mis   = (int'(redirect_target) % 4) != 0;
        end else begin
            m_mis = 0;
            if (fetch_en && (!m_valid || out_ready)) begin
                m_instr = mem[m_pc / 4];
                m_opc   = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 4) % 4096;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},    {31'b0, out_valid},    {31'b0, m_valid});
        chk({tag, ".pc"},       {20'b0, out_pc},       m_opc);
        chk({tag, ".instr"},    out_instr,             m_instr);
        chk({tag, ".imem"},     {20'b0, imem_addr},    m_pc);
        chk({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, m_mis});
    endtask

    // Apply inputs (already at posedge+1), advance one edge, update model, compare.
    task automatic step(input bit fe, input bit rdy, input bit rv, input logic [11:0] rt,
                        input string tag);
        fetch_en        = fe;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 12'h3a7;
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk); #1;
        check_all("reset_held");
        rst_n = 1'b1;

        // Streaming from reset with identity memory contents
        step(1, 1, 0, 12'h0, "s0");
        chk("s0.pc_const", {20'b0, out_pc}, 32'h000);
        chk("s0.instr_const", out_instr, 32'h1000_0000);
        step(1, 1, 0, 12'h0, "s1");
        chk("s1.pc_const", {20'b0, out_pc}, 32'h004);
        step(1, 1, 0, 12'h0, "s2");
        chk("s2.pc_const", {20'b0, out_pc}, 32'h008);
        chk("s2.instr_const", out_instr, 32'h1000_0002);

        // Stall holds everything
        for (int i = 0; i < 3; i++) step(1, 0, 0, 12'h0, "stall");
        chk("stall.pc_const", {20'b0, out_pc}, 32'h008);
        chk("stall.imem_const", {20'b0, imem_addr}, 32'h00C);
        step(1, 1, 0, 12'h0, "unstall");
        chk("unstall.pc_const", {20'b0, out_pc}, 32'h00C);

        // Redirect while stalled at 0x010 flushes it
        step(1, 1, 0, 12'h0, "to10");
        step(1, 0, 0, 12'h0, "st10");
        step(1, 0, 1, 12'h100, "redir100");
        chk("redir100.valid_const", {31'b0, out_valid}, 32'h0);
        chk("redir100.imem_const", {20'b0, imem_addr}, 32'h100);
        step(1, 1, 0, 12'h0, "after100");
        chk("after100.pc_const", {20'b0, out_pc}, 32'h100);

        // Misaligned target
        step(1, 1, 1, 12'h203, "redir203");
        chk("redir203.mis_const", {31'b0, misalign_err}, 32'h1);
        chk("redir203.imem_const", {20'b0, imem_addr}, 32'h200);
        step(1, 1, 0, 12'h0, "after203");
        chk("after203.pc_const", {20'b0, out_pc}, 32'h200);
        chk("after203.mis_const", {31'b0, misalign_err}, 32'h0);

        // Wrap at top of address space
        step(1, 1, 1, 12'hFFC, "redirFFC");
        step(1, 1, 0, 12'h0, "wrap0");
        chk("wrap0.pc_const", {20'b0, out_pc}, 32'hFFC);
        step(1, 1, 0, 12'h0, "wrap1");
        chk("wrap1.pc_const", {20'b0, out_pc}, 32'h000);
        chk("wrap1.mis_const", {31'b0, misalign_err}, 32'h0);

        // Back-to-back redirects, then transfer with fetch disabled
        step(1, 1, 1, 12'h300, "bb0");
        step(1, 1, 1, 12'h401, "bb1");
        step(1, 1, 0, 12'h0, "bb2");
        chk("bb2.pc_const", {20'b0, out_pc}, 32'h400);
        step(0, 1, 0, 12'h0, "fe0_xfer");
        step(0, 0, 0, 12'h0, "fe0_idle");

        // Async reset in the middle of a stall at 0x040
        step(1, 1, 1, 12'h040, "redir40");
        step(1, 0, 0, 12'h0, "get40");
        step(1, 0, 0, 12'h0, "st40");
        chk("st40.pc_const", {20'b0, out_pc}, 32'h040);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        chk("midreset.imem_const", {20'b0, imem_addr}, {20'b0, RPC});
        step(1, 1, 1, 12'h555, "reset_inputs");
        rst_n = 1'b1;
        #1;
        check_all("release");
        step(1, 1, 0, 12'h0, "first_after");
        chk("first_after.pc_const", {20'b0, out_pc}, {20'b0, RPC});

        // Randomized traffic with random memory contents
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0), 12'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
